store_pack_buffer: RTL
======================

Name: store_pack_buffer

Overview:
- Store-path counterpart of the immediate/load extenders: narrows 32-bit register data to byte/halfword/word stores.
- Replicates data across byte lanes, generates byte strobes and flags misaligned stores.
- Queues packed stores in a small FIFO that drains to the data-side AXI write master over a valid/ready handshake.
- Sits between the MEM stage and the bus interface. Drain status is exported so loads can be ordered behind pending stores.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 3, width of `count` output; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  exception/eret flush; synchronous, highest priority.
- in_valid  in  1  MEM stage presents a store.
- in_ready  out  1  buffer can accept (= !full).
- in_addr  in  32  byte address of store.
- in_data  in  32  register rt value.
- in_size  in  2  00 SB, 01 SH, 10 SW; 11 is illegal and treated as SW.
- adesr  out  1  registered one-cycle pulse: misaligned store rejected.
- badvaddr  out  32  address of the last misaligned store; holds until the next one.
- out_valid  out  1  head entry valid.
- out_ready  in  1  bus master consumes head.
- out_addr  out  32  head address, as captured.
- out_data  out  32  head lane-replicated data.
- out_strb  out  4  head byte strobes.
- out_size  out  2  head AXI size: 0, 1 or 2.
- empty  out  1  no entries pending.
- count  out  CNT_W  number of entries pending.

Behaviour:
- Reset (async): FIFO empty, pointers 0, out_valid=0, out_addr/out_data/out_strb/out_size=0, adesr=0, badvaddr=0, empty=1, count=0, in_ready=1.
- Accept: when in_valid && in_ready && !flush.
- Misalignment check:
  - SH is misaligned when addr[0]=1.
  - SW is misaligned when addr[1:0]!=0.
  - SB is never misaligned.
  - A misaligned store is accepted (consumed) but not enqueued. Next cycle adesr=1 for exactly one cycle and badvaddr=in_addr.
- Packing:
  - SB: data = {4{d[7:0]}}, strb = 4'b0001 << addr[1:0], size = 0.
  - SH: data = {2{d[15:0]}}, strb = addr[1] ? 4'b1100 : 4'b0011, size = 1.
  - SW: data = d, strb = 4'b1111, size = 2.
- Pop: out_valid && out_ready advances the head pointer.
- Outputs are driven from FIFO storage only, with no input-to-output combinational path. An accepted aligned store appears on out_* at the earliest the cycle after acceptance.
- Pointers wrap modulo DEPTH. Full when count=DEPTH; empty when count=0.
- Simultaneous push and pop: count unchanged. When full, in_ready=0 even if a pop occurs in that cycle, so there is no pop-to-push bypass.
- out_* hold stable while out_valid && !out_ready.
- flush:
  - Next edge: pointers=0, count=0, out_valid=0, adesr=0.
  - Same-cycle input is ignored and same-cycle pop is discarded.
  - badvaddr keeps its value.
- Reset mid-transfer: all entries are lost; no partial handshake completes.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined: an aligned store merges into the tail entry instead of allocating when all of the following hold:
  - the FIFO is non-empty;
  - the tail's addr[31:2] equals in_addr[31:2];
  - the tail is not being popped this cycle.
- Merge effect on the tail entry:
  - strb |= new strb;
  - data bytes with new strb set are overwritten;
  - size becomes 2;
  - addr becomes {addr[31:2],2'b00}.
- A merge may occur when full (in_ready is then asserted for that cycle) and leaves count unchanged.
- Undefined: every aligned store allocates its own entry.

Test Plan:
- Reset, then SB addr=0x1003 d=0x123456AB, out_ready=1 -> next cycle out_valid=1, out_data=0xABABABAB, out_strb=1000, out_size=0, out_addr=0x1003; count returns to 0.
- SH addr=0x2002 d=0xFFFF8001 -> out_data=0x80018001, strb=1100, size=1; SH addr=0x2001 -> not enqueued, adesr pulses once, badvaddr=0x2001.
- With out_ready=0, push 4 SW -> count=4, in_ready=0. Then out_ready=1 with in_valid held -> one pop per cycle; stores drain in order with correct data; push resumes only once count<4.
- Fill 2 entries, assert flush with in_valid=1 -> next cycle empty=1, out_valid=0, count=0; the input store is lost.
- Assert rst asynchronously while out_valid=1 and out_ready=0 -> outputs clear immediately, without a clock edge.
- STORE_MERGE_EN, out_ready=0: SB 0x3000 d=0x11, then SB 0x3002 d=0x22 -> count=1, strb=0101, data bytes 0 and 2 = 0x11 and 0x22, size=2. Without the macro -> count=2.

Source files
------------

// File: rtl/store_pack_buffer.sv
// store_pack_buffer
//   Store-path packer and write queue between the MEM stage and the data-side
//   AXI write master. Narrows 32-bit register data to byte/halfword/word
//   stores, replicates it across byte lanes and generates byte strobes. It
//   rejects misaligned stores by raising adesr and capturing badvaddr, and
//   queues aligned stores in a DEPTH-entry FIFO drained over valid/ready.
//
//   Optional feature (macro STORE_MERGE_EN): an aligned store whose word
//   address matches the tail entry is merged into that entry instead of
//   allocating a new one. With the macro undefined, every aligned store
//   allocates its own entry.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   flush             synchronous flush, highest priority
//   in_valid/in_ready store request handshake from the MEM stage
//   in_addr/in_data   byte address and register rt value
//   in_size           00 SB, 01 SH, 10 SW (11 behaves as SW)
//   adesr/badvaddr    one-cycle misaligned-store pulse, last bad address
//   out_valid/ready   head-entry handshake towards the bus master
//   out_addr/data/strb/size  head entry contents
//   empty, count      drain status used to order loads behind stores
module store_pack_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  output logic             adesr,
  output logic [31:0]      badvaddr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  output logic [1:0]       out_size,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      default: bad = (addr[1:0] != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] pack_data(input logic [31:0] d, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] pack_strb(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << addr[1:0];
      2'b01:   r = addr[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] pack_size(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      default: r = 2'd2;
    endcase
    return r;
  endfunction

  // FIFO storage; not reset, outputs are masked while the FIFO is empty
  logic [31:0] mem_addr_q [DEPTH];
  logic [31:0] mem_data_q [DEPTH];
  logic [3:0]  mem_strb_q [DEPTH];
  logic [1:0]  mem_size_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             adesr_q, adesr_d;
  logic [31:0]      badvaddr_q, badvaddr_d;

  logic             full, is_empty, mis, pop, accept, push, merge, merge_hit, in_ready_c;
  logic [31:0]      new_data;
  logic [3:0]       new_strb;
  logic [1:0]       new_size;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [31:0]      ent_addr_d, ent_data_d;
  logic [3:0]       ent_strb_d;
  logic [1:0]       ent_size_d;
`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0] tail_last;
`endif

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    is_empty = (count_q == '0);
    mis      = is_misaligned(in_addr, in_size);
    new_data = pack_data(in_data, in_size);
    new_strb = pack_strb(in_addr, in_size);
    new_size = pack_size(in_size);
    pop      = !is_empty && out_ready;

`ifdef STORE_MERGE_EN
    // Last written entry; it may not merge while it is leaving the FIFO.
    tail_last  = tail_q - PTR_W'(1);
    merge_hit  = !is_empty &&
                 (mem_addr_q[tail_last][31:2] == in_addr[31:2]) &&
                 !(pop && (count_q == CNT_W'(1)));
    // A merge needs no free slot, so it is accepted even when full.
    in_ready_c = !full || (in_valid && !mis && merge_hit);
`else
    merge_hit  = 1'b0;
    in_ready_c = !full;
`endif

    accept = in_valid && in_ready_c && !flush;
    push   = accept && !mis && !merge_hit;
    merge  = accept && !mis && merge_hit;

    wr_en      = push || merge;
    wr_idx     = tail_q;
    ent_addr_d = in_addr;
    ent_data_d = new_data;
    ent_strb_d = new_strb;
    ent_size_d = new_size;
`ifdef STORE_MERGE_EN
    if (merge) begin
      wr_idx     = tail_last;
      ent_addr_d = {mem_addr_q[tail_last][31:2], 2'b00};
      ent_strb_d = mem_strb_q[tail_last] | new_strb;
      ent_size_d = 2'd2;
      for (int b = 0; b < 4; b++) begin
        ent_data_d[8*b +: 8] = new_strb[b] ? new_data[8*b +: 8]
                                           : mem_data_q[tail_last][8*b +: 8];
      end
    end
`endif

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    adesr_d    = accept && mis;
    badvaddr_d = (accept && mis) ? in_addr : badvaddr_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      adesr_q    <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      adesr_q    <= adesr_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_addr_q[wr_idx] <= ent_addr_d;
      mem_data_q[wr_idx] <= ent_data_d;
      mem_strb_q[wr_idx] <= ent_strb_d;
      mem_size_q[wr_idx] <= ent_size_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign adesr     = adesr_q;
  assign badvaddr  = badvaddr_q;
  assign out_valid = !is_empty;
  assign out_addr  = is_empty ? '0 : mem_addr_q[head_q];
  assign out_data  = is_empty ? '0 : mem_data_q[head_q];
  assign out_strb  = is_empty ? '0 : mem_strb_q[head_q];
  assign out_size  = is_empty ? '0 : mem_size_q[head_q];
  assign empty     = is_empty;
  assign count     = count_q;

endmodule
